idex_stage: RTL and testbench

- ID/EX pipeline boundary of the LEGv8 pipelined core; sits directly downstream of the main decoder and register file.
- Registers the decoder control bundle, operands, immediate, PC and register indices into the EX stage.
- Contains load-use hazard detection: requests a one-cycle IF/ID stall and inserts a bubble into EX.
- Flushes to a bubble on a taken branch.

---
 rtl/idex_pkg.sv | 17 +
 rtl/idex_hazard_unit.sv | 26 ++
 rtl/idex_stage.sv | 161 ++++++++++++++++
 tb/tb_idex_stage.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/idex_pkg.sv
// Shared types and constants for the LEGv8 ID/EX pipeline boundary.
package idex_pkg;

    typedef struct packed {
        logic       ALUSrc;
        logic       MemtoReg;
        logic       RegWrite;
        logic       MemRead;
        logic       MemWrite;
        logic       Branch;
        logic [1:0] ALUOp;
    } ctrl_t;

    localparam logic [4:0] XZR         = 5'd31;
    localparam ctrl_t      CTRL_BUBBLE = '0;

endpackage

// File: rtl/idex_hazard_unit.sv
// Load-use hazard detection between the decode instruction and a load sitting in EX.
module hazard_unit
    import idex_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             valid_d,
    input  logic             uses1,
    input  logic             uses2,
    input  logic [REG_W-1:0] ra1_d,
    input  logic [REG_W-1:0] ra2_d,
    input  logic             valid_e,
    input  logic             mem_read_e,
    input  logic [REG_W-1:0] wa_e,
    output logic             hz
);

    localparam logic [REG_W-1:0] XZR_IDX = REG_W'(XZR);

    // A load writing XZR produces nothing to forward, so it never blocks a reader.
    always_comb begin
        hz = valid_d & valid_e & mem_read_e & (wa_e != XZR_IDX)
           & ((uses1 & (ra1_d == wa_e)) | (uses2 & (ra2_d == wa_e)));
    end

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use stall and branch flush.
// Optional IDEX_PERF_EN adds saturating stall/flush event counters.
module idex_stage
    import idex_pkg::*;
#(
    parameter int N     = 64,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid_d,
    input  logic             ALUSrc_d,
    input  logic             MemtoReg_d,
    input  logic             RegWrite_d,
    input  logic             MemRead_d,
    input  logic             MemWrite_d,
    input  logic             Branch_d,
    input  logic [1:0]       ALUOp_d,
    input  logic [N-1:0]     rd1_d,
    input  logic [N-1:0]     rd2_d,
    input  logic [N-1:0]     imm_d,
    input  logic [N-1:0]     pc_d,
    input  logic [REG_W-1:0] ra1_d,
    input  logic [REG_W-1:0] ra2_d,
    input  logic [REG_W-1:0] wa_d,
    input  logic [10:0]      funct_d,
    input  logic             flush_i,
    output logic             valid_e,
    output logic             ALUSrc_e,
    output logic             MemtoReg_e,
    output logic             RegWrite_e,
    output logic             MemRead_e,
    output logic             MemWrite_e,
    output logic             Branch_e,
    output logic [1:0]       ALUOp_e,
    output logic [N-1:0]     rd1_e,
    output logic [N-1:0]     rd2_e,
    output logic [N-1:0]     imm_e,
    output logic [N-1:0]     pc_e,
    output logic [REG_W-1:0] ra1_e,
    output logic [REG_W-1:0] ra2_e,
    output logic [REG_W-1:0] wa_e,
    output logic [10:0]      funct_e,
    output logic             stall_o
`ifdef IDEX_PERF_EN
    ,
    output logic [31:0]      stall_cnt_o,
    output logic [31:0]      flush_cnt_o
`endif
);

    ctrl_t            ctrl_in;
    logic             uses1, uses2, hz;

    logic             valid_e_q, valid_e_d;
    ctrl_t            ctrl_e_q, ctrl_e_d;
    logic [N-1:0]     rd1_e_q, rd1_e_d, rd2_e_q, rd2_e_d;
    logic [N-1:0]     imm_e_q, imm_e_d, pc_e_q, pc_e_d;
    logic [REG_W-1:0] ra1_e_q, ra1_e_d, ra2_e_q, ra2_e_d, wa_e_q, wa_e_d;
    logic [10:0]      funct_e_q, funct_e_d;

    assign ctrl_in = {ALUSrc_d, MemtoReg_d, RegWrite_d, MemRead_d, MemWrite_d, Branch_d, ALUOp_d};

    // CBZ reads only Rt; stores and branches read the second port even with ALUSrc set.
    assign uses1 = ~Branch_d;
    assign uses2 = ~ALUSrc_d | MemWrite_d | Branch_d;

    hazard_unit #(.REG_W(REG_W)) u_hazard (
        .valid_d    (valid_d),
        .uses1      (uses1),
        .uses2      (uses2),
        .ra1_d      (ra1_d),
        .ra2_d      (ra2_d),
        .valid_e    (valid_e_q),
        .mem_read_e (ctrl_e_q.MemRead),
        .wa_e       (wa_e_q),
        .hz         (hz)
    );

    assign stall_o = hz & ~flush_i;

    always_comb begin
        valid_e_d = valid_d;
        ctrl_e_d  = valid_d ? ctrl_in : CTRL_BUBBLE;
        if (flush_i || hz) begin
            valid_e_d = 1'b0;
            ctrl_e_d  = CTRL_BUBBLE;
        end
        rd1_e_d   = rd1_d;
        rd2_e_d   = rd2_d;
        imm_e_d   = imm_d;
        pc_e_d    = pc_d;
        ra1_e_d   = ra1_d;
        ra2_e_d   = ra2_d;
        wa_e_d    = wa_d;
        funct_e_d = funct_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_e_q <= 1'b0;
            ctrl_e_q  <= CTRL_BUBBLE;
            rd1_e_q   <= '0;
            rd2_e_q   <= '0;
            imm_e_q   <= '0;
            pc_e_q    <= '0;
            ra1_e_q   <= '0;
            ra2_e_q   <= '0;
            wa_e_q    <= '0;
            funct_e_q <= '0;
        end else begin
            valid_e_q <= valid_e_d;
            ctrl_e_q  <= ctrl_e_d;
            rd1_e_q   <= rd1_e_d;
            rd2_e_q   <= rd2_e_d;
            imm_e_q   <= imm_e_d;
            pc_e_q    <= pc_e_d;
            ra1_e_q   <= ra1_e_d;
            ra2_e_q   <= ra2_e_d;
            wa_e_q    <= wa_e_d;
            funct_e_q <= funct_e_d;
        end
    end

    assign valid_e = valid_e_q;
    assign {ALUSrc_e, MemtoReg_e, RegWrite_e, MemRead_e, MemWrite_e, Branch_e, ALUOp_e} = ctrl_e_q;
    assign rd1_e   = rd1_e_q;
    assign rd2_e   = rd2_e_q;
    assign imm_e   = imm_e_q;
    assign pc_e    = pc_e_q;
    assign ra1_e   = ra1_e_q;
    assign ra2_e   = ra2_e_q;
    assign wa_e    = wa_e_q;
    assign funct_e = funct_e_q;

`ifdef IDEX_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    // Both counters stick at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
        if (flush_i && valid_d && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_idex_stage.sv
// Self-checking bench for idex_stage: directed vector table, reset corner, and
// randomized traffic against an instruction-level reference model.
module tb_idex_stage;

    localparam int N     = 64;
    localparam int REG_W = 5;

    localparam logic [7:0] OP_ADD  = 8'h22;
    localparam logic [7:0] OP_LDUR = 8'hF0;
    localparam logic [7:0] OP_ADDI = 8'hA2;
    localparam logic [7:0] OP_CBZ  = 8'h05;
    localparam logic [7:0] OP_STUR = 8'h88;

    localparam int B_ALUSRC   = 7;
    localparam int B_MEMREAD  = 4;
    localparam int B_MEMWRITE = 3;
    localparam int B_BRANCH   = 2;

    typedef struct {
        logic        valid;
        logic [7:0]  ctrl;
        logic [63:0] rd1, rd2, imm, pc;
        logic [4:0]  ra1, ra2, wa;
        logic [10:0] funct;
        logic        flush;
    } din_t;

    typedef struct {
        din_t in;
        logic exp_stall;
        logic exp_valid;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    logic valid_d, ALUSrc_d, MemtoReg_d, RegWrite_d, MemRead_d, MemWrite_d, Branch_d;
    logic [1:0] ALUOp_d;
    logic [N-1:0] rd1_d, rd2_d, imm_d, pc_d;
    logic [REG_W-1:0] ra1_d, ra2_d, wa_d;
    logic [10:0] funct_d;
    logic flush_i;
    logic valid_e, ALUSrc_e, MemtoReg_e, RegWrite_e, MemRead_e, MemWrite_e, Branch_e;
    logic [1:0] ALUOp_e;
    logic [N-1:0] rd1_e, rd2_e, imm_e, pc_e;
    logic [REG_W-1:0] ra1_e, ra2_e, wa_e;
    logic [10:0] funct_e;
    logic stall_o;
`ifdef IDEX_PERF_EN
    logic [31:0] stall_cnt_o, flush_cnt_o;
    int m_stall_cnt, m_flush_cnt;
`endif

    int checks = 0;
    int failures = 0;

    din_t m_ex;
    vec_t tbl[24];

    always #5 clk = ~clk;

    idex_stage #(.N(N), .REG_W(REG_W)) dut (
        .clk(clk), .reset_n(reset_n), .valid_d(valid_d),
        .ALUSrc_d(ALUSrc_d), .MemtoReg_d(MemtoReg_d), .RegWrite_d(RegWrite_d),
        .MemRead_d(MemRead_d), .MemWrite_d(MemWrite_d), .Branch_d(Branch_d),
        .ALUOp_d(ALUOp_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d), .pc_d(pc_d),
        .ra1_d(ra1_d), .ra2_d(ra2_d), .wa_d(wa_d), .funct_d(funct_d), .flush_i(flush_i),
        .valid_e(valid_e), .ALUSrc_e(ALUSrc_e), .MemtoReg_e(MemtoReg_e),
        .RegWrite_e(RegWrite_e), .MemRead_e(MemRead_e), .MemWrite_e(MemWrite_e),
        .Branch_e(Branch_e), .ALUOp_e(ALUOp_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
        .imm_e(imm_e), .pc_e(pc_e), .ra1_e(ra1_e), .ra2_e(ra2_e), .wa_e(wa_e),
        .funct_e(funct_e), .stall_o(stall_o)
`ifdef IDEX_PERF_EN
        , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
    );

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic din_t mk(input logic v, input logic [7:0] c, input logic [4:0] r1,
                                input logic [4:0] r2, input logic [4:0] w, input logic f);
        din_t d;
        d.valid = v; d.ctrl = c; d.ra1 = r1; d.ra2 = r2; d.wa = w; d.flush = f;
        d.rd1 = {$urandom, $urandom}; d.rd2 = {$urandom, $urandom};
        d.imm = {$urandom, $urandom}; d.pc = {$urandom, $urandom};
        d.funct = 11'($urandom);
        return d;
    endfunction

    function automatic vec_t mkv(input din_t d, input logic s, input logic v);
        vec_t t;
        t.in = d; t.exp_stall = s; t.exp_valid = v;
        return t;
    endfunction

    // Does instruction d architecturally read register r as a source?
    function automatic logic readsReg(input din_t d, input logic [4:0] r);
        logic src1, src2;
        src1 = !d.ctrl[B_BRANCH];
        src2 = !d.ctrl[B_ALUSRC] || d.ctrl[B_MEMWRITE] || d.ctrl[B_BRANCH];
        return (src1 && d.ra1 == r) || (src2 && d.ra2 == r);
    endfunction

    // A valid load in EX whose (non-XZR) result is needed by the valid decode instruction.
    function automatic logic loadUse(input din_t d);
        return d.valid && m_ex.valid && m_ex.ctrl[B_MEMREAD] && m_ex.wa != 5'd31 && readsReg(d, m_ex.wa);
    endfunction

    function automatic logic [7:0] dutCtrl();
        return {ALUSrc_e, MemtoReg_e, RegWrite_e, MemRead_e, MemWrite_e, Branch_e, ALUOp_e};
    endfunction

    task automatic applyStimulus(input din_t d);
        valid_d = d.valid;
        {ALUSrc_d, MemtoReg_d, RegWrite_d, MemRead_d, MemWrite_d, Branch_d, ALUOp_d} = d.ctrl;
        rd1_d = d.rd1; rd2_d = d.rd2; imm_d = d.imm; pc_d = d.pc;
        ra1_d = d.ra1; ra2_d = d.ra2; wa_d = d.wa; funct_d = d.funct;
        flush_i = d.flush;
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".valid_e"}, 64'(valid_e), 64'(m_ex.valid));
        checkVal({tag, ".ctrl_e"}, 64'(dutCtrl()), 64'(m_ex.ctrl));
        if (m_ex.valid) begin
            checkVal({tag, ".rd1_e"}, rd1_e, m_ex.rd1);
            checkVal({tag, ".rd2_e"}, rd2_e, m_ex.rd2);
            checkVal({tag, ".imm_e"}, imm_e, m_ex.imm);
            checkVal({tag, ".pc_e"}, pc_e, m_ex.pc);
            checkVal({tag, ".ra1_e"}, 64'(ra1_e), 64'(m_ex.ra1));
            checkVal({tag, ".ra2_e"}, 64'(ra2_e), 64'(m_ex.ra2));
            checkVal({tag, ".wa_e"}, 64'(wa_e), 64'(m_ex.wa));
            checkVal({tag, ".funct_e"}, 64'(funct_e), 64'(m_ex.funct));
        end
    endtask

    task automatic modelReset();
        m_ex = mk(1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        m_ex.rd1 = '0; m_ex.rd2 = '0; m_ex.imm = '0; m_ex.pc = '0; m_ex.funct = '0;
`ifdef IDEX_PERF_EN
        m_stall_cnt = 0;
        m_flush_cnt = 0;
`endif
    endtask

    // One clock: drive, check the combinational stall, clock, advance model, check EX.
    task automatic runCycle(input din_t d, input string tag);
        logic exp_stall, kill;
        applyStimulus(d);
        #1;
        kill = loadUse(d);
        exp_stall = kill && !d.flush;
        checkVal({tag, ".stall_o"}, 64'(stall_o), 64'(exp_stall));
        @(posedge clk);
`ifdef IDEX_PERF_EN
        if (exp_stall) m_stall_cnt++;
        if (d.flush && d.valid) m_flush_cnt++;
`endif
        m_ex = d;
        m_ex.valid = d.valid && !d.flush && !kill;
        if (!m_ex.valid) m_ex.ctrl = 8'h00;
        #1;
        checkOutput(tag);
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, ".valid_e"}, 64'(valid_e), 64'd0);
        checkVal({tag, ".ctrl_e"}, 64'(dutCtrl()), 64'd0);
        checkVal({tag, ".data_e"}, rd1_e | rd2_e | imm_e | pc_e, 64'd0);
        checkVal({tag, ".idx_e"}, 64'({ra1_e, ra2_e, wa_e, funct_e}), 64'd0);
        checkVal({tag, ".stall_o"}, 64'(stall_o), 64'd0);
`ifdef IDEX_PERF_EN
        checkVal({tag, ".stall_cnt"}, 64'(stall_cnt_o), 64'd0);
        checkVal({tag, ".flush_cnt"}, 64'(flush_cnt_o), 64'd0);
`endif
    endtask

    initial begin
        din_t d;
        int n_stall, n_flush;
        string tag;

        tbl[0]  = mkv(mk(1, OP_ADD,  1,  2,  3, 0), 0, 1);
        tbl[1]  = mkv(mk(1, OP_LDUR, 1,  0,  5, 0), 0, 1);
        tbl[2]  = mkv(mk(1, OP_ADD,  5,  2,  6, 0), 1, 0);
        tbl[3]  = tbl[2]; tbl[3].exp_stall = 0; tbl[3].exp_valid = 1;
        tbl[4]  = mkv(mk(1, OP_LDUR, 1,  0, 31, 0), 0, 1);
        tbl[5]  = mkv(mk(1, OP_ADD, 31, 31,  7, 0), 0, 1);
        tbl[6]  = mkv(mk(1, OP_LDUR, 1,  0,  8, 0), 0, 1);
        tbl[7]  = mkv(mk(1, OP_ADDI, 1,  8,  9, 0), 0, 1);
        tbl[8]  = mkv(mk(1, OP_LDUR, 1,  0, 10, 0), 0, 1);
        tbl[9]  = mkv(mk(1, OP_CBZ,  0, 10,  0, 0), 1, 0);
        tbl[10] = tbl[9]; tbl[10].exp_stall = 0; tbl[10].exp_valid = 1;
        tbl[11] = mkv(mk(1, OP_LDUR, 1,  0, 11, 0), 0, 1);
        tbl[12] = mkv(mk(1, OP_ADD, 11,  2, 12, 1), 0, 0);
        tbl[13] = mkv(mk(0, OP_LDUR, 1,  0, 13, 0), 0, 0);
        tbl[14] = mkv(mk(1, OP_ADD, 13,  2, 14, 0), 0, 1);
        tbl[15] = mkv(mk(1, OP_LDUR, 2,  0, 15, 0), 0, 1);
        tbl[16] = mkv(mk(1, OP_STUR, 1, 15,  0, 0), 1, 0);
        tbl[17] = tbl[16]; tbl[17].exp_stall = 0; tbl[17].exp_valid = 1;
        tbl[18] = mkv(mk(1, OP_ADD,  1,  2,  3, 1), 0, 0);
        tbl[19] = mkv(mk(0, OP_ADD,  1,  2,  3, 1), 0, 0);
        tbl[20] = mkv(mk(1, OP_LDUR, 1,  0,  4, 0), 0, 1);
        tbl[21] = mkv(mk(1, OP_LDUR, 4,  0,  5, 0), 1, 0);
        tbl[22] = tbl[21]; tbl[22].exp_stall = 0; tbl[22].exp_valid = 1;
        tbl[23] = mkv(mk(1, OP_ADD,  1,  2,  6, 0), 0, 1);

        reset_n = 1'b0;
        applyStimulus(mk(0, 8'h00, 0, 0, 0, 0));
        modelReset();
        #3;
        checkAllZero("reset");
        #10 reset_n = 1'b1;

        n_stall = 0;
        n_flush = 0;
        foreach (tbl[i]) begin
            tag = $sformatf("vec%0d", i);
            applyStimulus(tbl[i].in);
            #1;
            checkVal({tag, ".stall_tbl"}, 64'(stall_o), 64'(tbl[i].exp_stall));
            runCycle(tbl[i].in, tag);
            checkVal({tag, ".valid_tbl"}, 64'(valid_e), 64'(tbl[i].exp_valid));
            checkVal({tag, ".ctrl_tbl"}, 64'(dutCtrl()),
                     64'(tbl[i].exp_valid ? tbl[i].in.ctrl : 8'h00));
            if (tbl[i].exp_valid)
                checkVal({tag, ".wa_tbl"}, 64'(wa_e), 64'(tbl[i].in.wa));
            if (tbl[i].exp_stall) n_stall++;
            if (tbl[i].in.flush && tbl[i].in.valid) n_flush++;
        end
`ifdef IDEX_PERF_EN
        checkVal("perf.stall_cnt", 64'(stall_cnt_o), 64'(n_stall));
        checkVal("perf.flush_cnt", 64'(flush_cnt_o), 64'(n_flush));
`endif

        // Reset asserted between edges with a valid ADD in EX must clear at once.
        runCycle(mk(1, OP_ADD, 1, 2, 3, 0), "pre_reset");
        applyStimulus(mk(1, OP_LDUR, 3, 0, 4, 0));
        #2 reset_n = 1'b0;
        #1;
        checkAllZero("midreset");
        modelReset();
        #3 reset_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            logic [7:0] ops [5];
            logic [4:0] r [3];
            ops = '{OP_ADD, OP_LDUR, OP_ADDI, OP_CBZ, OP_STUR};
            for (int k = 0; k < 3; k++)
                r[k] = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
            d = mk($urandom_range(0, 9) != 0, ops[$urandom_range(0, 4)], r[0], r[1], r[2],
                   $urandom_range(0, 9) == 0);
            runCycle(d, $sformatf("rnd%0d", i));
        end
`ifdef IDEX_PERF_EN
        checkVal("rnd.stall_cnt", 64'(stall_cnt_o), 64'(m_stall_cnt));
        checkVal("rnd.flush_cnt", 64'(flush_cnt_o), 64'(m_flush_cnt));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
